// File: rtl/sqrt_result_checker.sv
// sqrt_result_checker: verifies root == floor(sqrt(x)) via shift-add squaring; SQCHK_RESIDUE_EN adds the residue port
module sqrt_result_checker #(
  parameter int W     = 16,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2*W-1:0]   x,
  input  logic [W-1:0]     root,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             pass,
  output logic [CNT_W-1:0] err_count
`ifdef SQCHK_RESIDUE_EN
  ,
  output logic [2*W:0]     residue
`endif
);
  localparam int IW = $clog2(W);
  typedef enum logic [1:0] {IDLE, MUL, CMP, DONE} state_t;
  state_t state_q, state_d;
  logic [2*W-1:0] x_q, x_d, acc_q, acc_d;
  logic [W-1:0] root_q, root_d;
  logic [IW-1:0] idx_q, idx_d;
  logic pass_q, pass_d, in_ready_q, in_ready_d, out_valid_q, out_valid_d;
  logic [CNT_W-1:0] err_q, err_d;
  logic [2*W:0] r;
`ifdef SQCHK_RESIDUE_EN
  logic [2*W:0] residue_q, residue_d;
  assign residue = residue_q;
`endif
  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign pass      = pass_q;
  assign err_count = err_q;
  // signed difference x - root^2, one extra bit so a too-large root shows as negative
  always_comb r = {1'b0, x_q} - {1'b0, acc_q};
  // next-state, multiplier step, verdict and error counter
  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    root_d    = root_q;
    acc_d     = acc_q;
    idx_d     = idx_q;
    pass_d    = pass_q;
    err_d     = err_q;
`ifdef SQCHK_RESIDUE_EN
    residue_d = residue_q;
`endif
    case (state_q)
      IDLE: if (in_valid) begin
        x_d     = x;
        root_d  = root;
        acc_d   = '0;
        idx_d   = '0;
        state_d = MUL;
      end
      MUL: begin
        if (root_q[idx_q]) acc_d = acc_q + ({{W{1'b0}}, root_q} << idx_q);
        idx_d = idx_q + 1'b1;
        if (idx_q == IW'(W - 1)) state_d = CMP;
      end
      CMP: begin
        pass_d    = !r[2*W] && (r <= {{W{1'b0}}, root_q, 1'b0});
`ifdef SQCHK_RESIDUE_EN
        residue_d = r;
`endif
        state_d   = DONE;
      end
      DONE: if (out_ready) begin
        state_d = IDLE;
        if (!pass_q && !(&err_q)) err_d = err_q + 1'b1;
      end
    endcase
    in_ready_d  = state_d == IDLE;
    out_valid_d = state_d == DONE;
  end
  // state and output registers, cleared asynchronously
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      x_q         <= '0;
      root_q      <= '0;
      acc_q       <= '0;
      idx_q       <= '0;
      pass_q      <= 1'b0;
      err_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
`ifdef SQCHK_RESIDUE_EN
      residue_q   <= '0;
`endif
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      root_q      <= root_d;
      acc_q       <= acc_d;
      idx_q       <= idx_d;
      pass_q      <= pass_d;
      err_q       <= err_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
`ifdef SQCHK_RESIDUE_EN
      residue_q   <= residue_d;
`endif
    end
  end
endmodule
